// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 fetch stage.
//   - icode constants (I_HALT .. I_POPQ)
//   - status codes (STAT_AOK/HLT/ADR/INS)
//   - RNONE: register id meaning "no register"
//   - fetch_state_e: fetch sequencer states
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH,
        S_OUT,
        S_WAIT,
        S_STOP
    } fetch_state_e;

endpackage

// File: rtl/y86_instr_len.sv
// Combinational decode of an instruction's first byte.
// Ports:
//   byte0       in   {icode, ifun}
//   length      out  instruction length in bytes (1, 2, 9 or 10)
//   has_regids  out  byte 1 carries {rA, rB}
//   has_valc    out  instruction carries an 8-byte constant
//   valc_offset out  index of the first valC byte (1 or 2)
//   invalid     out  icode or ifun is not a legal encoding
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [7:0] byte0,
    output logic [3:0] length,
    output logic       has_regids,
    output logic       has_valc,
    output logic [3:0] valc_offset,
    output logic       invalid
);

    logic [3:0] icode;
    logic [3:0] ifun;

    assign icode = byte0[7:4];
    assign ifun  = byte0[3:0];

    always_comb begin
        length      = 4'd1;
        has_regids  = 1'b0;
        has_valc    = 1'b0;
        valc_offset = 4'd0;
        invalid     = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                length  = 4'd1;
                invalid = (ifun != 4'd0);
            end
            I_RRMOVQ: begin
                length     = 4'd2;
                has_regids = 1'b1;
                invalid    = (ifun > 4'd6);
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                length      = 4'd10;
                has_regids  = 1'b1;
                has_valc    = 1'b1;
                valc_offset = 4'd2;
                invalid     = (ifun != 4'd0);
            end
            I_OPQ: begin
                length     = 4'd2;
                has_regids = 1'b1;
                invalid    = (ifun > 4'd3);
            end
            I_JXX: begin
                length      = 4'd9;
                has_valc    = 1'b1;
                valc_offset = 4'd1;
                invalid     = (ifun > 4'd6);
            end
            I_CALL: begin
                length      = 4'd9;
                has_valc    = 1'b1;
                valc_offset = 4'd1;
                invalid     = (ifun != 4'd0);
            end
            I_PUSHQ, I_POPQ: begin
                length     = 4'd2;
                has_regids = 1'b1;
                invalid    = (ifun != 4'd0);
            end
            default: begin
                length  = 4'd1;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Y86-64 fetch stage. Reads an instruction one byte per transfer from an 8-bit
// instruction memory, splits it into fields and presents it downstream with a
// valid/ready handshake, then waits for the next PC from later stages.
// Ports:
//   clock, reset         rising-edge clock; synchronous active-low reset
//   imem_req/imem_addr   byte read request, address = pc + byte_cnt
//   imem_valid/rdata/err transfer completion, data byte, address fault
//   f_valid/f_ready      downstream handshake
//   icode/ifun/rA/rB     instruction fields
//   valC/valP/pc_out     constant, fall-through PC, instruction address
//   stat                 1=AOK 2=HLT 3=ADR 4=INS
//   pc_next_valid/pc_next  next PC from execute/memory (used only in S_WAIT)
module fetch_unit
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_valid,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_error,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] pc_out,
    output logic [2:0]  stat,
    input  logic        pc_next_valid,
    input  logic [63:0] pc_next
);

    fetch_state_e state_q, state_d;

    logic [63:0] pc_q, pc_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic        imem_req_q, imem_req_d;
    logic        f_valid_q, f_valid_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [63:0] valc_q, valc_d;
    logic [63:0] valp_q, valp_d;
    logic [63:0] pc_out_q, pc_out_d;
    logic [2:0]  stat_q, stat_d;

    // Byte 0 is decoded straight off the bus; later bytes reuse the stored fields.
    logic [7:0] dec_byte;
    logic [3:0] dec_len;
    logic       dec_regids;
    logic       dec_valc;
    logic [3:0] dec_off;
    logic       dec_invalid;

    assign dec_byte = (byte_cnt_q == 4'd0) ? imem_rdata : {icode_q, ifun_q};

    y86_instr_len u_instr_len (
        .byte0      (dec_byte),
        .length     (dec_len),
        .has_regids (dec_regids),
        .has_valc   (dec_valc),
        .valc_offset(dec_off),
        .invalid    (dec_invalid)
    );

    logic       xfer;
    logic       xfer_ok;
    logic       fault;
    logic       is_invalid;
    logic       is_halt;
    logic       is_last;
    logic       fetch_done;
    logic [3:0] valc_rel;

    assign xfer       = (state_q == S_FETCH) & imem_req_q & imem_valid;
    assign fault      = xfer & imem_error;
    assign xfer_ok    = xfer & ~imem_error;
    assign is_invalid = xfer_ok & (byte_cnt_q == 4'd0) & dec_invalid;
    // halt with a nonzero ifun is also flagged invalid; INS wins in the stat select
    assign is_halt    = xfer_ok & (byte_cnt_q == 4'd0) & (imem_rdata[7:4] == I_HALT);
    assign is_last    = xfer_ok & (byte_cnt_q == (dec_len - 4'd1));
    assign fetch_done = fault | is_invalid | is_halt | is_last;
    assign valc_rel   = byte_cnt_q - dec_off;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (fetch_done) state_d = S_OUT;
            S_OUT: begin
                if (f_valid_q && f_ready) begin
                    state_d = (stat_q == STAT_AOK) ? S_WAIT : S_STOP;
                end
            end
            S_WAIT:  if (pc_next_valid) state_d = S_FETCH;
            S_STOP:  state_d = S_STOP;
            default: state_d = S_FETCH;
        endcase
    end

    // Output / datapath next values. Request and valid are registered copies of
    // the next state, so they rise exactly one cycle after the transition cause.
    always_comb begin
        imem_req_d = (state_d == S_FETCH);
        f_valid_d  = (state_d == S_OUT);
        pc_d       = pc_q;
        byte_cnt_d = byte_cnt_q;
        icode_d    = icode_q;
        ifun_d     = ifun_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        valc_d     = valc_q;
        valp_d     = valp_q;
        pc_out_d   = pc_out_q;
        stat_d     = stat_q;
        case (state_q)
            S_FETCH: begin
                if (xfer_ok) begin
                    if (byte_cnt_q == 4'd0) begin
                        icode_d = imem_rdata[7:4];
                        ifun_d  = imem_rdata[3:0];
                    end
                    if (byte_cnt_q == 4'd1 && dec_regids) begin
                        ra_d = imem_rdata[7:4];
                        rb_d = imem_rdata[3:0];
                    end
                    if (dec_valc && byte_cnt_q >= dec_off) begin
                        // little-endian: byte (off + k) lands in valC[8k +: 8]
                        for (int k = 0; k < 8; k++) begin
                            if (valc_rel == 4'(k)) valc_d[8*k +: 8] = imem_rdata;
                        end
                    end
                    if (!fetch_done) byte_cnt_d = byte_cnt_q + 4'd1;
                end
                if (fetch_done) begin
                    pc_out_d = pc_q;
                    if (fault) begin
                        stat_d = STAT_ADR;
                        valp_d = 64'd0;
                    end else if (is_invalid) begin
                        stat_d = STAT_INS;
                        valp_d = pc_q + 64'd1;
                    end else if (is_halt) begin
                        stat_d = STAT_HLT;
                        valp_d = pc_q + 64'd1;
                    end else begin
                        stat_d = STAT_AOK;
                        valp_d = pc_q + 64'(dec_len);
                    end
                end
            end
            S_WAIT: begin
                if (pc_next_valid) begin
                    // fields start from defaults so a faulting fetch reports
                    // only what it actually captured
                    pc_d       = pc_next;
                    byte_cnt_d = 4'd0;
                    icode_d    = 4'd0;
                    ifun_d     = 4'd0;
                    ra_d       = RNONE;
                    rb_d       = RNONE;
                    valc_d     = 64'd0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            byte_cnt_q <= 4'd0;
            imem_req_q <= 1'b0;
            f_valid_q  <= 1'b0;
            icode_q    <= 4'd0;
            ifun_q     <= 4'd0;
            ra_q       <= RNONE;
            rb_q       <= RNONE;
            valc_q     <= 64'd0;
            valp_q     <= 64'd0;
            pc_out_q   <= 64'd0;
            stat_q     <= STAT_AOK;
        end else begin
            pc_q       <= pc_d;
            byte_cnt_q <= byte_cnt_d;
            imem_req_q <= imem_req_d;
            f_valid_q  <= f_valid_d;
            icode_q    <= icode_d;
            ifun_q     <= ifun_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            valc_q     <= valc_d;
            valp_q     <= valp_d;
            pc_out_q   <= pc_out_d;
            stat_q     <= stat_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q + {60'd0, byte_cnt_q};
    assign f_valid   = f_valid_q;
    assign icode     = icode_q;
    assign ifun      = ifun_q;
    assign rA        = ra_q;
    assign rB        = rb_q;
    assign valC      = valc_q;
    assign valP      = valp_q;
    assign pc_out    = pc_out_q;
    assign stat      = stat_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed instructions followed by random ones, with a
// per-instruction behavioural model and a per-cycle checker.
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'd0;

    localparam int P_RST   = 0;
    localparam int P_FETCH = 1;
    localparam int P_OUT   = 2;
    localparam int P_WAIT  = 3;
    localparam int P_STOP  = 4;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [7:0]  imem_rdata;
    logic        imem_error;
    logic        f_valid;
    logic        f_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc_out;
    logic [2:0]  stat;
    logic        pc_next_valid;
    logic [63:0] pc_next;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .imem_error   (imem_error),
        .f_valid      (f_valid),
        .f_ready      (f_ready),
        .icode        (icode),
        .ifun         (ifun),
        .rA           (rA),
        .rB           (rB),
        .valC         (valC),
        .valP         (valP),
        .pc_out       (pc_out),
        .stat         (stat),
        .pc_next_valid(pc_next_valid),
        .pc_next      (pc_next)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [63:0]     pc;
        logic [9:0][7:0] b;
        int              err_idx;
        int              hold;
        int              rst_at;
        bit              dense;
        bit              new_ep;
    } item_t;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        int          nxfer;
    } exp_t;

    // Expected outcome of fetching bytes b at pc, with an address fault on
    // byte err_idx (-1 for none).
    function automatic exp_t model(input logic [63:0] pc, input logic [9:0][7:0] b,
                                   input int err_idx);
        exp_t e;
        int len;
        bit bad;
        logic [3:0] ic, fn;
        e.icode = 4'h0; e.ifun = 4'h0; e.ra = 4'hF; e.rb = 4'hF;
        e.valc = 64'd0; e.valp = 64'd0; e.stat = 3'd1; e.nxfer = 0;
        ic = b[0][7:4];
        fn = b[0][3:0];
        case (ic)
            4'h0, 4'h1, 4'h9:        len = 1;
            4'h2, 4'h6, 4'hA, 4'hB:  len = 2;
            4'h7, 4'h8:              len = 9;
            4'h3, 4'h4, 4'h5:        len = 10;
            default:                 len = 1;
        endcase
        if (ic > 4'hB)                      bad = 1;
        else if (ic == 4'h2 || ic == 4'h7)  bad = (fn > 4'h6);
        else if (ic == 4'h6)                bad = (fn > 4'h3);
        else                                bad = (fn != 4'h0);
        for (int k = 0; k < len; k++) begin
            e.nxfer = k + 1;
            if (k == err_idx) begin
                e.stat = 3'd3;
                return e;
            end
            if (k == 0) begin
                e.icode = ic;
                e.ifun  = fn;
                if (bad) begin
                    e.stat = 3'd4;
                    e.valp = pc + 64'd1;
                    return e;
                end
                if (ic == 4'h0) begin
                    e.stat = 3'd2;
                    e.valp = pc + 64'd1;
                    return e;
                end
            end
            if (k == 1 && ((ic >= 4'h2 && ic <= 4'h6) || ic == 4'hA || ic == 4'hB)) begin
                e.ra = b[1][7:4];
                e.rb = b[1][3:0];
            end
            if ((ic == 4'h7 || ic == 4'h8) && k >= 1) e.valc[8*(k-1) +: 8] = b[k];
            if ((ic >= 4'h3 && ic <= 4'h5) && k >= 2) e.valc[8*(k-2) +: 8] = b[k];
        end
        e.valp = pc + 64'(len);
        return e;
    endfunction

    // Bench-side view of where the DUT must be after the most recent edge.
    int              phase = P_RST;
    logic [63:0]     cur_pc = 64'd0;
    int              xfers = 0;
    exp_t            exp_cur;

    int n_cmp = 0;
    int n_bad = 0;
    bit pinned = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pin_model();
        exp_t e;
        e = model(64'h100, 80'h0123456789ABCDEFF330, -1);
        chk("pin_irmovq_rb", 64'(e.rb), 64'h3);
        chk("pin_irmovq_ra", 64'(e.ra), 64'hF);
        chk("pin_irmovq_valc", e.valc, 64'h0123456789ABCDEF);
        chk("pin_irmovq_valp", e.valp, 64'h10A);
        chk("pin_irmovq_len", 64'(e.nxfer), 64'd10);
        e = model(64'h200, 80'h00112233445566778874, -1);
        chk("pin_jxx_valc", e.valc, 64'h1122334455667788);
        chk("pin_jxx_valp", e.valp, 64'h209);
        e = model(64'h0, 80'hC0, -1);
        chk("pin_c0_stat", 64'(e.stat), 64'd4);
        chk("pin_c0_len", 64'(e.nxfer), 64'd1);
        e = model(64'h0, 80'h67, -1);
        chk("pin_67_stat", 64'(e.stat), 64'd4);
        e = model(64'h0, 80'h00, -1);
        chk("pin_halt_stat", 64'(e.stat), 64'd2);
        chk("pin_halt_valp", e.valp, 64'd1);
        e = model(64'h300, 80'h551240, 3);
        chk("pin_adr_stat", 64'(e.stat), 64'd3);
        chk("pin_adr_ra", 64'(e.ra), 64'h1);
        chk("pin_adr_valc", e.valc, 64'h55);
        chk("pin_adr_len", 64'(e.nxfer), 64'd4);
    endtask

    // Per-cycle compare, sampled on the falling edge.
    always @(negedge clock) begin
        if (!pinned) begin
            pinned = 1;
            pin_model();
        end
        case (phase)
            P_RST: begin
                chk("rst_req", 64'(imem_req), 64'd0);
                chk("rst_fvalid", 64'(f_valid), 64'd0);
                chk("rst_icode", 64'(icode), 64'd0);
                chk("rst_ifun", 64'(ifun), 64'd0);
                chk("rst_ra", 64'(rA), 64'hF);
                chk("rst_rb", 64'(rB), 64'hF);
                chk("rst_valc", valC, 64'd0);
                chk("rst_valp", valP, 64'd0);
                chk("rst_pc_out", pc_out, 64'd0);
                chk("rst_stat", 64'(stat), 64'd1);
            end
            P_FETCH: begin
                chk("fetch_req", 64'(imem_req), 64'd1);
                chk("fetch_fvalid", 64'(f_valid), 64'd0);
                chk("fetch_addr", imem_addr, cur_pc + 64'(xfers));
            end
            P_OUT: begin
                chk("out_req", 64'(imem_req), 64'd0);
                chk("out_fvalid", 64'(f_valid), 64'd1);
                chk("out_icode", 64'(icode), 64'(exp_cur.icode));
                chk("out_ifun", 64'(ifun), 64'(exp_cur.ifun));
                chk("out_ra", 64'(rA), 64'(exp_cur.ra));
                chk("out_rb", 64'(rB), 64'(exp_cur.rb));
                chk("out_valc", valC, exp_cur.valc);
                chk("out_valp", valP, exp_cur.valp);
                chk("out_pc", pc_out, cur_pc);
                chk("out_stat", 64'(stat), 64'(exp_cur.stat));
            end
            default: begin
                chk("idle_req", 64'(imem_req), 64'd0);
                chk("idle_fvalid", 64'(f_valid), 64'd0);
            end
        endcase
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Random noise on every input the DUT must ignore in the current phase.
    task automatic drive_idle();
        imem_valid    = 1'($urandom);
        imem_error    = 1'($urandom);
        imem_rdata    = 8'($urandom);
        f_ready       = 1'($urandom);
        pc_next       = {$urandom, $urandom};
        pc_next_valid = (phase == P_WAIT) ? 1'b0 : 1'($urandom);
    endtask

    task automatic load(input item_t it, input logic [63:0] pc);
        cur_pc  = pc;
        xfers   = 0;
        exp_cur = model(pc, it.b, it.err_idx);
        phase   = P_FETCH;
    endtask

    task automatic do_instr(input item_t it, input bit first, output bit ended);
        int hold;
        ended = 0;
        if (first) begin
            tick(); drive_idle(); reset = 1'b0; phase = P_RST;
            tick(); drive_idle(); reset = 1'b1; load(it, RESET_PC);
        end else begin
            tick(); drive_idle(); pc_next_valid = 1'b1; pc_next = it.pc; load(it, it.pc);
        end
        while (phase == P_FETCH) begin
            tick();
            drive_idle();
            if (it.rst_at >= 0 && xfers == it.rst_at) begin
                imem_valid = 1'b1;
                reset = 1'b0;
                phase = P_RST;
                ended = 1;
                return;
            end
            imem_valid = it.dense ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (imem_valid) begin
                imem_rdata = it.b[xfers];
                imem_error = (xfers == it.err_idx);
                xfers++;
                if (xfers == exp_cur.nxfer) phase = P_OUT;
            end
        end
        hold = it.hold;
        while (phase == P_OUT) begin
            tick();
            drive_idle();
            f_ready = (hold > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (hold > 0) hold--;
            if (f_ready) phase = (exp_cur.stat == 3'd1) ? P_WAIT : P_STOP;
        end
        if (phase == P_STOP) begin
            repeat (3) begin tick(); drive_idle(); end
            ended = 1;
        end else begin
            repeat ($urandom_range(0, 3)) begin tick(); drive_idle(); end
        end
    endtask

    function automatic item_t mk(input logic [63:0] pc, input logic [79:0] b, input int err,
                                 input int hold, input int rst_at, input bit new_ep);
        item_t it;
        it.pc = pc; it.b = b; it.err_idx = err; it.hold = hold;
        it.rst_at = rst_at; it.dense = 1; it.new_ep = new_ep;
        return it;
    endfunction

    function automatic item_t rand_item();
        item_t it;
        int r;
        logic [3:0] ic, fn;
        for (int k = 0; k < 10; k++) it.b[k] = 8'($urandom);
        r = $urandom_range(0, 19);
        if (r < 15) begin
            ic = 4'($urandom_range(1, 11));
            if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
            else if (ic == 4'h6)          fn = 4'($urandom_range(0, 3));
            else                          fn = 4'h0;
            it.b[0] = {ic, fn};
        end else if (r == 19) begin
            it.b[0] = 8'h00;
        end
        it.pc      = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFA : {$urandom, $urandom};
        it.err_idx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : -1;
        it.rst_at  = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 4) : -1;
        it.hold    = $urandom_range(0, 2);
        it.dense   = ($urandom_range(0, 3) == 0);
        it.new_ep  = 0;
        return it;
    endfunction

    item_t dir [9];

    initial begin
        bit ended, fst;
        reset         = 1'b0;
        imem_valid    = 1'b0;
        imem_error    = 1'b0;
        imem_rdata    = 8'h00;
        f_ready       = 1'b0;
        pc_next_valid = 1'b0;
        pc_next       = 64'd0;

        dir[0] = mk(64'h0,   80'h10,                   -1, 0, -1, 1);
        dir[1] = mk(64'h1,   80'hAB20,                 -1, 0, -1, 0);
        dir[2] = mk(64'h100, 80'h0123456789ABCDEFF330, -1, 1, -1, 0);
        dir[3] = mk(64'h200, 80'h00112233445566778874, -1, 5, -1, 0);
        dir[4] = mk(64'h300, 80'h551240,                3, 0, -1, 0);
        dir[5] = mk(64'h0,   80'hC0,                   -1, 0, -1, 1);
        dir[6] = mk(64'h0,   80'h67,                   -1, 2, -1, 1);
        dir[7] = mk(64'h0,   80'h00,                   -1, 0, -1, 1);
        dir[8] = mk(64'h0,   80'h0123456789ABCDEFF330, -1, 0,  5, 1);

        ended = 1;
        for (int i = 0; i < 9; i++) begin
            fst = ended | dir[i].new_ep;
            do_instr(dir[i], fst, ended);
        end
        for (int i = 0; i < 200; i++) begin
            fst = ended;
            do_instr(rand_item(), fst, ended);
        end
        repeat (3) begin tick(); drive_idle(); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
